progmem_loader: RTL and testbench

- Byte-stream loader that writes a program image into the instruction memory the CPU fetches from; it is the writer end of the CPU's instruction-fetch interface.
- Accepts bytes over a valid/ready handshake, assembles big-endian instructions, and writes them to consecutive addresses from BASE_ADDR.
- Holds the CPU (cpu_hold) for the whole load.
- Sits beside the PC register and program memory; cpu_hold is ORed into the CPU reset.

---
 rtl/progmem_loader_pkg.sv | 24 ++
 rtl/progmem_loader_shifter.sv | 48 ++++
 rtl/progmem_loader.sv | 195 +++++++++++++++++++
 tb/tb_progmem_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/progmem_loader_pkg.sv
// Shared constants for the program-memory loader: FSM state encoding and byte geometry.
// Optional checksum stage is selected with PROGMEM_LOADER_CHK_EN.
package progmem_loader_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_HI = 3'd1;
    localparam state_t ST_LEN_LO = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_WRITE  = 3'd4;
    localparam state_t ST_CHK    = 3'd5;
    localparam state_t ST_FIN    = 3'd6;
    localparam state_t ST_ERR    = 3'd7;

    // Number of stream bytes that make up one instruction word.
    function automatic int unsigned bytes_per_instr(input int unsigned instr_w);
        return instr_w / BYTE_W;
    endfunction

endpackage

// File: rtl/progmem_loader_shifter.sv
// Byte-to-word assembly register: shifts bytes in MSB-first and flags the byte
// that completes an instruction word.
module progmem_shifter
    import progmem_loader_pkg::*;
#(
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [BYTE_W-1:0]  in_byte,
    output logic [INSTR_W-1:0] word_c,
    output logic               word_full_c
);

    localparam int unsigned BPI   = bytes_per_instr(INSTR_W);
    localparam int unsigned CNT_W = (BPI > 1) ? $clog2(BPI) : 1;

    logic [INSTR_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;

    // word_c already contains the byte being loaded this cycle.
    always_comb begin
        word_c      = INSTR_W'({word_q, in_byte});
        word_full_c = load && (cnt_q == CNT_W'(BPI - 1));
        word_d      = word_q;
        cnt_d       = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (load) begin
            word_d = word_c;
            cnt_d  = word_full_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/progmem_loader.sv
// Program-memory loader: length-prefixed big-endian byte stream -> instruction memory writes,
// holding the CPU in reset while loading. Define PROGMEM_LOADER_CHK_EN for a trailing XOR checksum byte.
module progmem_loader
    import progmem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned INSTR_W   = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wd,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned MAX_N = (2 ** ADDR_W) - BASE_ADDR;

    state_t             state_q, state_d;
    logic [7:0]         len_hi_q, len_hi_d;
    logic [LEN_W-1:0]   n_q, n_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0] mem_wd_q, mem_wd_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef PROGMEM_LOADER_CHK_EN
    logic [7:0]         chk_q, chk_d;
`endif

    logic               xfer;
    logic [LEN_W-1:0]   hdr_n;
    logic               len_ok;
    logic [INSTR_W-1:0] word_c;
    logic               word_full_c;

    // Abort wins over a same-cycle byte: the byte is left unconsumed.
    assign xfer   = in_valid && in_ready_q && !abort;
    assign hdr_n  = LEN_W'({len_hi_q, in_data});
    assign len_ok = (hdr_n != '0) && (32'(hdr_n) <= MAX_N);

    progmem_shifter #(
        .INSTR_W (INSTR_W)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .clear       (state_q == ST_IDLE),
        .load        (xfer && (state_q == ST_DATA)),
        .in_byte     (in_data),
        .word_c      (word_c),
        .word_full_c (word_full_c)
    );

    // State and registered datapath/outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_hi_q   <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PROGMEM_LOADER_CHK_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            cpu_hold_q <= cpu_hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef PROGMEM_LOADER_CHK_EN
            chk_q      <= chk_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LEN_HI;
            ST_LEN_HI: if (xfer) state_d = ST_LEN_LO;
            ST_LEN_LO: if (xfer) state_d = len_ok ? ST_DATA : ST_ERR;
            ST_DATA:   if (xfer && word_full_c) state_d = ST_WRITE;
            ST_WRITE: begin
                if ((idx_q + LEN_W'(1)) == n_q) begin
`ifdef PROGMEM_LOADER_CHK_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_FIN;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef PROGMEM_LOADER_CHK_EN
            ST_CHK:    if (xfer) state_d = (in_data == chk_q) ? ST_FIN : ST_ERR;
`endif
            ST_FIN:    state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE) && (state_q != ST_ERR)) begin
            state_d = ST_ERR;
        end
    end

    // Output and datapath next values.
    always_comb begin
        len_hi_d   = len_hi_q;
        n_d        = n_q;
        idx_d      = idx_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        cpu_hold_d = cpu_hold_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        in_ready_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) || (state_d == ST_DATA);
`ifdef PROGMEM_LOADER_CHK_EN
        chk_d      = chk_q;
        if (state_d == ST_CHK) in_ready_d = 1'b1;
        if ((state_q == ST_IDLE) && start) chk_d = '0;
        if ((state_q == ST_DATA) && xfer) chk_d = chk_q ^ in_data;
`endif

        if ((state_q == ST_IDLE) && start) begin
            done_d     = 1'b0;
            err_d      = 1'b0;
            busy_d     = 1'b1;
            cpu_hold_d = 1'b1;
            idx_d      = '0;
        end
        if ((state_q == ST_LEN_HI) && xfer) len_hi_d = in_data;
        if ((state_q == ST_LEN_LO) && xfer) n_d = hdr_n;

        // Write strobe is registered, so it is raised on the edge that accepts the last byte.
        if ((state_q == ST_DATA) && (state_d == ST_WRITE)) begin
            mem_we_d   = 1'b1;
            mem_addr_d = ADDR_W'(BASE_ADDR + 32'(idx_q));
            mem_wd_d   = word_c;
        end
        if (state_q == ST_WRITE) idx_d = idx_q + LEN_W'(1);

        if ((state_q == ST_FIN) && (state_d == ST_IDLE)) begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            cpu_hold_d = 1'b0;
        end
        if (state_q == ST_ERR) begin
            err_d      = 1'b1;
            busy_d     = 1'b0;
            cpu_hold_d = 1'b0;
        end
    end

    assign in_ready = in_ready_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign cpu_hold = cpu_hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_progmem_loader.sv
// Self-checking bench for progmem_loader: directed scenarios plus randomized loads
// checked against a stream-level model of the expected memory writes and status.
module tb_progmem_loader;

    typedef logic [7:0] byte_q_t[$];

    localparam int unsigned MAX_N = 1024;

    logic        clk = 1'b0;
    logic        reset, start, abort, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_hold, busy, done, err;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wd;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int viol  = 0;
    int wa[$];
    int wd[$];
    int wc[$];
    int xcyc[$];

    always #5 clk = ~clk;

    progmem_loader #(
        .ADDR_W    (10),
        .INSTR_W   (16),
        .BASE_ADDR (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Record accepted bytes (cycle stamp) on the active edge.
    always @(posedge clk) begin
        cyc++;
        if (!reset && in_valid && in_ready && !abort) xcyc.push_back(cyc);
    end

    // Capture memory writes away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(int'(mem_addr));
            wd.push_back(int'(mem_wd));
            wc.push_back(cyc);
            if (in_ready) viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_capture();
        wa.delete(); wd.delete(); wc.delete(); xcyc.delete();
        viol = 0;
    endtask

    task automatic start_load();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit poke);
        int t;
        if (gap) begin
            @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom); start = 1'b0;
        end
        @(negedge clk); in_valid = 1'b1; in_data = b; start = poke;
        t = 0;
        while (!in_ready && t < 64) begin
            @(negedge clk); t++;
        end
        check("ready_wait", in_ready, 1);
    endtask

    task automatic end_stream();
        @(negedge clk); in_valid = 1'b0; start = 1'b0; in_data = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 20 && busy; t++) @(negedge clk);
        check("busy_end", busy, 0);
    endtask

    // Legal stream: header N (optional junk in the ignored high bits), 2N random bytes, checksum if enabled.
    function automatic byte_q_t make_stream(input int n, input logic [4:0] junk);
        byte_q_t q;
        logic [7:0]  x;
        logic [7:0]  b;
        logic [15:0] h;
        x = 8'h00;
        h = 16'(n) | {junk, 11'h000};
        q.push_back(h[15:8]);
        q.push_back(h[7:0]);
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            x ^= b;
            q.push_back(b);
        end
`ifdef PROGMEM_LOADER_CHK_EN
        q.push_back(x);
`endif
        return q;
    endfunction

    // Reference: which writes and which final status the stream must produce.
    task automatic compare(input byte_q_t s);
        int         n;
        int         nexp;
        bit         legal;
        bit         ok;
        bit         bad;
        logic [7:0] x;
        n     = int'({s[0], s[1]} & 16'h07FF);
        legal = (n >= 1) && (n <= int'(MAX_N));
        ok    = legal;
        nexp  = legal ? n : 0;
`ifdef PROGMEM_LOADER_CHK_EN
        if (legal) begin
            x = 8'h00;
            for (int i = 2; i < 2 + 2 * n; i++) x ^= s[i];
            ok = (s[2 + 2 * n] == x);
        end
`endif
        check("n_writes", wa.size(), nexp);
        bad = 1'b0;
        for (int i = 0; i < nexp && i < wa.size() && !bad; i++) begin
            bad = (wa[i] != i) || (wd[i] != int'({s[2 + 2 * i], s[3 + 2 * i]})) ||
                  (wc[i] != xcyc[3 + 2 * i]);
            check("wr_addr", wa[i], i);
            check("wr_data", wd[i], {16'h0, s[2 + 2 * i], s[3 + 2 * i]});
            check("wr_latency", wc[i], xcyc[3 + 2 * i]);
        end
        check("done", done, ok);
        check("err", err, !ok);
        check("hold_after", cpu_hold, 0);
        check("ready_in_write", viol, 0);
        check("bytes_taken", xcyc.size(), s.size());
    endtask

    task automatic run_load(input byte_q_t s, input int gap_pct, input bit poke);
        clear_capture();
        start_load();
        check("busy_during", busy, 1);
        check("hold_during", cpu_hold, 1);
        foreach (s[i]) send_byte(s[i], $urandom_range(99) < gap_pct, poke && (i == 3));
        end_stream();
        wait_idle();
        compare(s);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wd"}, mem_wd, 0);
        check({tag, "_hold"}, cpu_hold, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        byte_q_t s;
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;

        // Basic load, continuous then every-other-cycle valid.
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROGMEM_LOADER_CHK_EN
        s.push_back(8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD);
`endif
        run_load(s, 0, 1'b0);
        run_load(s, 100, 1'b0);

        // Zero length: error, no write, idle two cycles after the second header byte.
        clear_capture();
        start_load();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        end_stream();
        @(negedge clk);
        check("zero_busy", busy, 0);
        check("zero_err", err, 1);
        check("zero_done", done, 0);
        check("zero_writes", wa.size(), 0);

        // Abort presented together with byte 56: one write survives, byte not taken.
        clear_capture();
        start_load();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        @(negedge clk); in_valid = 1'b1; in_data = 8'h56;
        for (int t = 0; t < 8 && !in_ready; t++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0; in_valid = 1'b0;
        check("abort_ready", in_ready, 0);
        wait_idle();
        check("abort_writes", wa.size(), 1);
        if (wa.size() > 0) begin
            check("abort_addr", wa[0], 0);
            check("abort_data", wd[0], 32'h1234);
        end
        check("abort_err", err, 1);
        check("abort_done", done, 0);
        check("abort_bytes", xcyc.size(), 4);

        // Reset in the middle of DATA, then a clean load.
        clear_capture();
        start_load();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'hBE, 1'b0, 1'b0);
        end_stream();
        #2 reset = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk); reset = 1'b0;
        s = '{8'h00, 8'h01, 8'hBE, 8'hEF};
`ifdef PROGMEM_LOADER_CHK_EN
        s.push_back(8'hBE ^ 8'hEF);
`endif
        run_load(s, 0, 1'b0);

        // start and abort together in IDLE: start wins; a later abort ends in error.
        clear_capture();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("sa_busy", busy, 1);
        check("sa_hold", cpu_hold, 1);
        check("sa_ready", in_ready, 1);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        wait_idle();
        check("sa_err", err, 1);
        check("sa_writes", wa.size(), 0);

        // Header range boundaries: 1025 rejected, bit 11 ignored (reads as 0), high junk ignored.
        s = '{8'h04, 8'h01};
        run_load(s, 0, 1'b0);
        s = '{8'h08, 8'h00};
        run_load(s, 0, 1'b0);
        run_load(make_stream(1, 5'h1F), 30, 1'b0);

        // Full memory: last address written is 1023.
        run_load(make_stream(1024, 5'h00), 0, 1'b0);
        if (wa.size() > 0) check("max_last_addr", wa[wa.size() - 1], 1023);

        // Randomized loads with random gaps; odd runs also pulse start while busy.
        for (int k = 0; k < 10; k++) begin
            run_load(make_stream($urandom_range(1, 6), 5'($urandom)), $urandom_range(0, 60), k[0]);
        end

`ifdef PROGMEM_LOADER_CHK_EN
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        run_load(s, 0, 1'b0);
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
        run_load(s, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            s = make_stream($urandom_range(1, 4), 5'h00);
            s[s.size() - 1] = s[s.size() - 1] ^ 8'($urandom_range(1, 255));
            run_load(s, 20, 1'b0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
